// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of a FIFO write port, holding each grant for a packet or a bounded burst.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_REQ-1:0]            i_last,
  input  logic                          i_full,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_wr,
  output logic [DATA_WIDTH-1:0]         o_w_data,
  output logic                          o_busy
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] g_q, g_d, ptr_q, ptr_d, pick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic rel;
  // Scan downward so the requester closest to ptr wins.
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (i_req[(int'(ptr_q) + i) % NUM_REQ]) pick = GW'((int'(ptr_q) + i) % NUM_REQ);
  end
  always_comb begin
    o_busy   = state_q == GRANT;
    o_grant  = grant_q;
    o_wr     = o_busy & i_req[g_q] & ~i_full;
    o_ack    = o_wr ? NUM_REQ'(1) << g_q : '0;
    o_w_data = o_busy ? i_data[g_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    rel      = o_busy & (~i_req[g_q] | (o_wr & (i_last[g_q] | cnt_q == CW'(MAX_BURST - 1))));
    state_d  = state_q;
    g_d      = g_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    if (state_q == IDLE && |i_req) begin
      state_d = GRANT;
      g_d     = pick;
      cnt_d   = '0;
      grant_d = NUM_REQ'(1) << pick;
    end else if (rel) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d   = g_q == GW'(NUM_REQ - 1) ? '0 : g_q + 1'b1;
    end else if (o_wr) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
endmodule
